// File: rtl/serializer_stream_if.sv
// serializer_stream_if: word handshake in, framed serial bit out.
// master drives words in; slave is the serializer side.
interface serializer_stream_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_value;
  logic              o_bit;
  logic              o_valid;
  logic              o_first;
  logic              o_last;
  logic              busy;

  modport master (
    output in_valid,
    output in_value,
    input  in_ready,
    input  o_bit,
    input  o_valid,
    input  o_first,
    input  o_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready,
    output o_bit,
    output o_valid,
    output o_first,
    output o_last,
    output busy
  );
endinterface

// File: rtl/serializer_stream.sv
// serializer_stream: DATA_W-bit words to a framed bit-serial line.
// One holding register lets back-to-back words stream gap-free.
module serializer_stream #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  serializer_stream_if.slave bus
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] load_w;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              hold_full_q, hold_full_d;
  logic              bit_q, bit_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              in_ready;
  logic              accept;
  logic              free;
  logic              load;

  assign in_ready = !hold_full_q && !rst;
  assign accept   = bus.in_valid && in_ready;
  assign free     = (state_q == IDLE) || last_q;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    cnt_d       = cnt_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    first_d     = first_q;
    last_d      = last_q;
    load        = 1'b0;
    load_w      = bus.in_value;

    // A held word always wins the shifter over a fresh one
    if (free) begin
      if (hold_full_q) begin
        load        = 1'b1;
        load_w      = hold_q;
        hold_full_d = 1'b0;
      end else if (accept) begin
        load = 1'b1;
      end
    end else if (accept) begin
      hold_d      = bus.in_value;
      hold_full_d = 1'b1;
    end

    unique case (1'b1)
      load: begin
        state_d = SHIFT;
        bit_d   = MSB_FIRST ? load_w[DATA_W-1] : load_w[0];
        shreg_d = MSB_FIRST ? (load_w << 1) : (load_w >> 1);
        cnt_d   = '0;
        first_d = 1'b1;
        last_d  = 1'b0;
      end
      !free: begin
        bit_d   = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d   = cnt_q + 1'b1;
        first_d = 1'b0;
        last_d  = (cnt_q == CW'(DATA_W - 2));
      end
      default: begin
        state_d = IDLE;
        bit_d   = IDLE_BIT;
        first_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= IDLE_BIT;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    hold_q  <= hold_d;
  end

  assign bus.in_ready = in_ready;
  assign bus.o_bit    = bit_q;
  assign bus.o_valid  = (state_q == SHIFT);
  assign bus.o_first  = first_q;
  assign bus.o_last   = last_q;
  assign bus.busy     = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_serializer_stream.sv
// tb_serializer_stream: scoreboard bench for three serializer
// configurations (8b MSB-first, 8b LSB-first, 12b idle-high).
module tb_serializer_stream;
  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  bit   acc_a, acc_b, acc_c;

  serializer_stream_if #(.DATA_W(8))  ia ();
  serializer_stream_if #(.DATA_W(8))  ib ();
  serializer_stream_if #(.DATA_W(12)) ic ();

  serializer_stream #(
    .DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)
  ) dut_a (.clk(clk), .rst(rst), .bus(ia));

  serializer_stream #(
    .DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .bus(ib));

  serializer_stream #(
    .DATA_W(12), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)
  ) dut_c (.clk(clk), .rst(rst), .bus(ic));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int w, bit msb,
                              logic [15:0] v, int i);
    exp_t e;
    int   idx;
    idx = msb ? (w - 1 - i) : i;
    e.b = v[idx];
    e.f = (i == 0);
    e.l = (i == w - 1);
    return e;
  endfunction

  // One clock edge; expected bits are queued for every accept.
  task automatic tick();
    logic [15:0] va, vb, vc;
    bit          rs;
    rs    = rst;
    acc_a = !rs && ia.in_valid && ia.in_ready;
    acc_b = !rs && ib.in_valid && ib.in_ready;
    acc_c = !rs && ic.in_valid && ic.in_ready;
    va    = {8'h00, ia.in_value};
    vb    = {8'h00, ib.in_value};
    vc    = {4'h0, ic.in_value};
    @(posedge clk);
    if (rs) begin
      qa.delete();
      qb.delete();
      qc.delete();
    end else begin
      if (acc_a) for (int i = 0; i < 8; i++) qa.push_back(mk(8, 1, va, i));
      if (acc_b) for (int i = 0; i < 8; i++) qb.push_back(mk(8, 0, vb, i));
      if (acc_c) for (int i = 0; i < 12; i++) qc.push_back(mk(12, 1, vc, i));
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ia.o_valid, ia.o_bit, ia.o_first, ia.o_last, ia.busy,
         ia.in_ready} !== 6'b000000) begin
      failures++;
      $display("FAIL reset_a got v/b/f/l/busy/rdy=%b want 000000",
               {ia.o_valid, ia.o_bit, ia.o_first, ia.o_last,
                ia.busy, ia.in_ready});
    end
    checks++;
    if ({ic.o_valid, ic.o_bit, ic.busy, ic.in_ready} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_c got v/b/busy/rdy=%b want 0100",
               {ic.o_valid, ic.o_bit, ic.busy, ic.in_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ia.in_ready, ib.in_ready, ic.in_ready} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release got rdy=%b want 111",
               {ia.in_ready, ib.in_ready, ic.in_ready});
    end
  endtask

  task automatic test_single_msb();
    exp_t       e;
    logic [3:0] want;
    bit         hf;
    logic [7:0] seen;
    int         firsts, lasts;
    seen = '0;
    firsts = 0;
    lasts = 0;
    ia.in_value = 8'h1E;
    ia.in_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      ia.in_valid = 1'b0;
      want = 4'b0000;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qa.size() >= 8);
      if (ia.o_valid) seen = {seen[6:0], ia.o_bit};
      if (ia.o_first) firsts = firsts + c;
      if (ia.o_last) lasts = lasts + c;
      checks++;
      if ({ia.o_valid, ia.o_bit, ia.o_first, ia.o_last} !== want ||
          ia.busy !== (want[3] | hf) || ia.in_ready !== !hf) begin
        failures++;
        $display("FAIL single_msb cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c, {ia.o_valid, ia.o_bit, ia.o_first, ia.o_last},
                 ia.busy, ia.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (seen !== 8'h1E || firsts != 1 || lasts != 8) begin
      failures++;
      $display("FAIL single_msb_frame got bits=%h first=%0d last=%0d want 1e 1 8",
               seen, firsts, lasts);
    end
  endtask

  task automatic test_single_lsb();
    exp_t       e;
    logic [3:0] want;
    bit         hf;
    logic [7:0] seen;
    int         firsts, lasts;
    seen = '0;
    firsts = 0;
    lasts = 0;
    ib.in_value = 8'h1E;
    ib.in_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      ib.in_valid = 1'b0;
      want = 4'b0000;
      if (qb.size() != 0) begin
        e = qb.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qb.size() >= 8);
      if (ib.o_valid) seen = {seen[6:0], ib.o_bit};
      if (ib.o_first) firsts = firsts + c;
      if (ib.o_last) lasts = lasts + c;
      checks++;
      if ({ib.o_valid, ib.o_bit, ib.o_first, ib.o_last} !== want ||
          ib.busy !== (want[3] | hf) || ib.in_ready !== !hf) begin
        failures++;
        $display("FAIL single_lsb cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c, {ib.o_valid, ib.o_bit, ib.o_first, ib.o_last},
                 ib.busy, ib.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (seen !== 8'h78 || firsts != 1 || lasts != 8) begin
      failures++;
      $display("FAIL single_lsb_frame got bits=%h first=%0d last=%0d want 78 1 8",
               seen, firsts, lasts);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [3:0]  want;
    bit          hf;
    logic [7:0]  w [3];
    logic [31:0] fmask, vmask, rmask;
    int          k;
    w[0] = 8'hA5;
    w[1] = 8'h3C;
    w[2] = 8'hFF;
    k = 0;
    fmask = '0;
    vmask = '0;
    rmask = '0;
    ia.in_value = w[0];
    ia.in_valid = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (acc_a) begin
        k++;
        if (k < 3) ia.in_value = w[k];
        else ia.in_valid = 1'b0;
      end
      want = 4'b0000;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qa.size() >= 8);
      if (ia.o_first) fmask[c] = 1'b1;
      if (ia.o_valid) vmask[c] = 1'b1;
      if (ia.in_ready && c <= 9) rmask[c] = 1'b1;
      checks++;
      if ({ia.o_valid, ia.o_bit, ia.o_first, ia.o_last} !== want ||
          ia.busy !== (want[3] | hf) || ia.in_ready !== !hf) begin
        failures++;
        $display("FAIL stream cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c, {ia.o_valid, ia.o_bit, ia.o_first, ia.o_last},
                 ia.busy, ia.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (fmask !== 32'h0002_0202 || vmask !== 32'h01FF_FFFE ||
        rmask !== 32'h0000_0202) begin
      failures++;
      $display("FAIL stream_frame got first=%h valid=%h rdy=%h want 00020202 01fffffe 00000202",
               fmask, vmask, rmask);
    end
  endtask

  task automatic test_backpressure();
    exp_t       e;
    logic [3:0] want;
    bit         hf;
    int         n;
    n = 0;
    ia.in_value = 8'h11;
    ia.in_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (acc_a) n++;
      if (n >= 3) ia.in_valid = 1'b0;
      ia.in_value = 8'($urandom);
      want = 4'b0000;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qa.size() >= 8);
      checks++;
      if ({ia.o_valid, ia.o_bit, ia.o_first, ia.o_last} !== want ||
          ia.busy !== (want[3] | hf) || ia.in_ready !== !hf) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c, {ia.o_valid, ia.o_bit, ia.o_first, ia.o_last},
                 ia.busy, ia.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL backpressure_accepts got %0d want 3", n);
    end
  endtask

  task automatic test_reset_mid_word();
    exp_t       e;
    logic [3:0] want;
    bit         hf;
    logic [7:0] seen;
    seen = '0;
    for (int c = 0; c <= 16; c++) begin
      unique case (c)
        0: begin ia.in_valid = 1'b1; ia.in_value = 8'hA5; end
        1: ia.in_value = 8'h3C;
        2: ia.in_valid = 1'b0;
        5: begin rst = 1'b1; ia.in_valid = 1'b1; ia.in_value = 8'hEE; end
        6: begin ia.in_valid = 1'b1; ia.in_value = 8'h5A; end
        7: ia.in_valid = 1'b0;
        default: ;
      endcase
      tick();
      rst = 1'b0;
      #1;
      want = 4'b0000;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qa.size() >= 8);
      if (c >= 6 && ia.o_valid) seen = {seen[6:0], ia.o_bit};
      checks++;
      if ({ia.o_valid, ia.o_bit, ia.o_first, ia.o_last} !== want ||
          ia.busy !== (want[3] | hf) || ia.in_ready !== !hf) begin
        failures++;
        $display("FAIL reset_mid cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c + 1, {ia.o_valid, ia.o_bit, ia.o_first, ia.o_last},
                 ia.busy, ia.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (seen !== 8'h5A) begin
      failures++;
      $display("FAIL reset_mid_word_after got %h want 5a", seen);
    end
  endtask

  task automatic test_wide_idle_high();
    exp_t        e;
    logic [3:0]  want;
    bit          hf;
    logic [11:0] seen;
    int          last_cyc;
    seen = '0;
    last_cyc = 0;
    ic.in_value = 12'h801;
    ic.in_valid = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      ic.in_valid = 1'b0;
      want = 4'b0100;
      if (qc.size() != 0) begin
        e = qc.pop_front();
        want = {1'b1, e.b, e.f, e.l};
      end
      hf = (qc.size() >= 12);
      if (ic.o_valid) seen = {seen[10:0], ic.o_bit};
      if (ic.o_last) last_cyc = c;
      checks++;
      if ({ic.o_valid, ic.o_bit, ic.o_first, ic.o_last} !== want ||
          ic.busy !== (want[3] | hf) || ic.in_ready !== !hf) begin
        failures++;
        $display("FAIL wide cyc=%0d got vbfl=%b busy=%b rdy=%b want vbfl=%b busy=%b rdy=%b",
                 c, {ic.o_valid, ic.o_bit, ic.o_first, ic.o_last},
                 ic.busy, ic.in_ready, want, want[3] | hf, !hf);
      end
    end
    checks++;
    if (seen !== 12'h801 || last_cyc != 12) begin
      failures++;
      $display("FAIL wide_frame got bits=%h last=%0d want 801 12",
               seen, last_cyc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    ia.in_valid = 1'b0;
    ia.in_value = '0;
    ib.in_valid = 1'b0;
    ib.in_value = '0;
    ic.in_valid = 1'b0;
    ic.in_value = '0;
    test_reset();
    test_single_msb();
    test_single_lsb();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_wide_idle_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serializer_stream.md
Name: serializer_stream

Overview:
Parametrised parallel-to-serial converter, successor to the 8-bit load/shift serializer. It accepts DATA_W-bit words over a valid/ready handshake and emits them one bit per clock on a single serial line, with frame markers. A one-entry holding buffer lets consecutive words stream with no idle gap. It sits between word-oriented producers (FIFOs, packetisers) and bit-serial line drivers.

Parameters:
- DATA_W, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, 1 = bit DATA_W-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, value driven on o_bit whenever o_valid is 0.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word on in_value.
- in_ready  out  1  block can take a word this cycle.
- in_value  in  DATA_W  parallel word.
- o_bit  out  1  serial data, registered.
- o_valid  out  1  o_bit carries a data bit this cycle.
- o_first  out  1  o_bit is the first bit of a word.
- o_last  out  1  o_bit is the last bit of a word.
- busy  out  1  o_valid OR hold_full.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Internal state: shift register shreg[DATA_W-1:0], bit counter cnt (ceil(log2 DATA_W) bits), holding register hold[DATA_W-1:0], hold_full flag, and the output registers.
- Transfer: a word is accepted on a rising edge where in_valid && in_ready. in_ready = !hold_full && !rst, decoded combinationally from registers only, with no path from in_valid.
- Shifter free at an edge: free = !o_valid || o_last.
- Actions at each edge, in priority order:
  - Free and hold_full: load hold into the shifter; hold_full <= 0.
  - Free, hold empty, and a word accepted: load in_value directly into the shifter.
  - Not free and a word accepted: hold <= in_value; hold_full <= 1.
  - Free and nothing to load: o_valid <= 0, o_first <= 0, o_last <= 0, o_bit <= IDLE_BIT.
- On load: o_bit <= first bit per MSB_FIRST; o_valid <= 1; o_first <= 1; o_last <= 0; cnt <= 0; shreg holds the remaining bits.
- While shifting (not free): o_bit <= next bit; cnt <= cnt+1; o_first <= 0; o_last <= (cnt+1 == DATA_W-1).
- Latency: a word accepted at edge N into an idle block shows its first bit in the cycle after edge N. Its last bit shows in the cycle after edge N+DATA_W-1.
- Throughput: with in_valid held high, o_valid stays high continuously. in_ready pulses once per word, one word per DATA_W cycles.
- State machine, 2 states implied by o_valid:
  - IDLE -> SHIFT on a load.
  - SHIFT -> SHIFT on the o_last edge when a word is available (hold or accept).
  - SHIFT -> IDLE on the o_last edge when no word is available.
- The in_value bus is sampled only on an accepting edge; it may change at any other time.
- Reset (any cycle, including mid-word): o_valid, o_first, o_last, hold_full and cnt <= 0; o_bit <= IDLE_BIT. The in-flight word and the held word are discarded, not completed. in_ready is 0 while rst is high, and in_valid is ignored.
- Accept on the o_last edge with hold empty: the incoming word goes straight to the shifter. hold_full stays 0, so there is no bubble.
- o_first and o_last are never high in the same cycle (DATA_W is 2 or more).

Test Plan:
- Single word, MSB_FIRST=1, in_value=0x1E accepted at edge 0: o_bit = 0,0,0,1,1,1,1,0 in cycles 1-8. o_first is high in cycle 1 only, o_last in cycle 8 only. o_valid is 0 with o_bit = IDLE_BIT from cycle 9.
- Same word with MSB_FIRST=0: o_bit = 0,1,1,1,1,0,0,0 in cycles 1-8, with the same frame-marker timing.
- Streaming: words 0xA5, 0x3C, 0xFF presented with in_valid held high: o_valid is high for 24 contiguous cycles. 0x3C is held from edge 1 and in_ready is low until edge 8. o_first goes high at cycles 1, 9 and 17.
- Backpressure: with hold_full, in_valid held high and in_value changing every cycle: no accept occurs while in_ready=0. The word accepted is the value present on the edge where in_ready returns to 1.
- Reset mid-word: rst asserted for 1 cycle at bit 4 of 0xA5 while 0x3C is held: the next cycle has o_valid=0, busy=0, in_ready=1. A word sent after reset serialises cleanly from cycle 1.
- DATA_W=12, IDLE_BIT=1, in_value=0x801 MSB-first: bits 1, then ten 0s, then 1. o_last is high in cycle 12, and o_bit=1 while idle before and after the word.
